// File: rtl/rs_issue_station.sv
// Reservation station: fills free slots from dispatch, wakes sources off the CDB,
// maintains / squashes on branch masks and selects ready entries onto N issue lanes.
module rs_issue_station #(
  parameter int  RS_SZ = 8,
  parameter int  N     = 2,
  parameter int  TAG_W = 6,
  parameter int  BM_W  = 4,
  parameter int  PAY_W = 32,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CNT_W-1:0]   num_dispatched,
  input  logic [N*TAG_W-1:0] dis_dest,
  input  logic [N*TAG_W-1:0] dis_src1,
  input  logic [N*TAG_W-1:0] dis_src2,
  input  logic [N-1:0]       dis_src1_rdy,
  input  logic [N-1:0]       dis_src2_rdy,
  input  logic [N*BM_W-1:0]  dis_bmask,
  input  logic [N*PAY_W-1:0] dis_payload,
  output logic [CNT_W-1:0]   rs_spots,
  input  logic [N-1:0]       cdb_valid,
  input  logic [N*TAG_W-1:0] cdb_tags,
  input  logic [BM_W-1:0]    b_mm_resolve,
  input  logic               b_mm_mispred,
  input  logic [N-1:0]       fu_avail,
  output logic [N-1:0]       iss_valid,
  output logic [N*TAG_W-1:0] iss_dest,
  output logic [N*TAG_W-1:0] iss_src1,
  output logic [N*TAG_W-1:0] iss_src2,
  output logic [N*BM_W-1:0]  iss_bmask,
  output logic [N*PAY_W-1:0] iss_payload
);

  logic [RS_SZ-1:0] valid;
  logic [RS_SZ-1:0] src1_rdy;
  logic [RS_SZ-1:0] src2_rdy;
  logic [TAG_W-1:0] dest    [RS_SZ];
  logic [TAG_W-1:0] src1    [RS_SZ];
  logic [TAG_W-1:0] src2    [RS_SZ];
  logic [BM_W-1:0]  bmask   [RS_SZ];
  logic [PAY_W-1:0] payload [RS_SZ];

  logic [RS_SZ-1:0] wake1, wake2, squash, eligible, issued;
  logic [N-1:0]     alloc_oh [RS_SZ];
  logic [N-1:0]     lane_rdy1, lane_rdy2, lane_kill;
  logic [BM_W-1:0]  lane_bmask [N];
  int               free_cnt;

  function automatic logic cdb_hit(input logic [TAG_W-1:0]   tag,
                                   input logic [N-1:0]       vld,
                                   input logic [N*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < N; j++)
      if (vld[j] && tags[j*TAG_W +: TAG_W] == tag) hit = 1'b1;
    return hit;
  endfunction

  // Eligibility is gated by reset so nothing issues during the reset cycle.
  always_comb begin
    free_cnt = 0;
    for (int i = 0; i < RS_SZ; i++) begin
      wake1[i]    = cdb_hit(src1[i], cdb_valid, cdb_tags);
      wake2[i]    = cdb_hit(src2[i], cdb_valid, cdb_tags);
      squash[i]   = b_mm_mispred && ((bmask[i] & b_mm_resolve) != '0);
      eligible[i] = reset && valid[i] && src1_rdy[i] && src2_rdy[i] && !squash[i];
      if (!valid[i]) free_cnt = free_cnt + 1;
    end
  end

  assign rs_spots = (free_cnt >= N) ? CNT_W'(N) : CNT_W'(free_cnt);

  always_comb begin
    for (int k = 0; k < N; k++) begin
      lane_rdy1[k]  = dis_src1_rdy[k] || cdb_hit(dis_src1[k*TAG_W +: TAG_W], cdb_valid, cdb_tags);
      lane_rdy2[k]  = dis_src2_rdy[k] || cdb_hit(dis_src2[k*TAG_W +: TAG_W], cdb_valid, cdb_tags);
      lane_bmask[k] = dis_bmask[k*BM_W +: BM_W] & ~b_mm_resolve;
      lane_kill[k]  = b_mm_mispred && ((dis_bmask[k*BM_W +: BM_W] & b_mm_resolve) != '0);
    end
  end

  // Lane k maps to the k-th lowest free slot; a killed lane still consumes its slot position.
  always_comb begin
    int taken;
    int limit;
    taken = 0;
    limit = (int'(num_dispatched) < int'(rs_spots)) ? int'(num_dispatched) : int'(rs_spots);
    for (int i = 0; i < RS_SZ; i++) begin
      alloc_oh[i] = '0;
      if (!valid[i] && taken < limit) begin
        for (int k = 0; k < N; k++)
          if (k == taken) alloc_oh[i][k] = 1'b1;
        taken = taken + 1;
      end
    end
  end

  always_comb begin
    logic [RS_SZ-1:0] used;
    logic             got;
    used        = '0;
    got         = 1'b0;
    iss_valid   = '0;
    iss_dest    = '0;
    iss_src1    = '0;
    iss_src2    = '0;
    iss_bmask   = '0;
    iss_payload = '0;
    for (int k = 0; k < N; k++) begin
      got = 1'b0;
      for (int i = 0; i < RS_SZ; i++) begin
        if (fu_avail[k] && !got && eligible[i] && !used[i]) begin
          got                            = 1'b1;
          used[i]                        = 1'b1;
          iss_valid[k]                   = 1'b1;
          iss_dest[k*TAG_W +: TAG_W]     = dest[i];
          iss_src1[k*TAG_W +: TAG_W]     = src1[i];
          iss_src2[k*TAG_W +: TAG_W]     = src2[i];
          iss_bmask[k*BM_W +: BM_W]      = bmask[i] & ~b_mm_resolve;
          iss_payload[k*PAY_W +: PAY_W]  = payload[i];
        end
      end
    end
    issued = used;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < RS_SZ; i++) begin
        if (valid[i]) begin
          if (issued[i] || squash[i]) valid[i] <= 1'b0;
          if (wake1[i]) src1_rdy[i] <= 1'b1;
          if (wake2[i]) src2_rdy[i] <= 1'b1;
          bmask[i] <= bmask[i] & ~b_mm_resolve;
        end else begin
          for (int k = 0; k < N; k++) begin
            if (alloc_oh[i][k] && !lane_kill[k]) begin
              valid[i]    <= 1'b1;
              dest[i]     <= dis_dest[k*TAG_W +: TAG_W];
              src1[i]     <= dis_src1[k*TAG_W +: TAG_W];
              src2[i]     <= dis_src2[k*TAG_W +: TAG_W];
              src1_rdy[i] <= lane_rdy1[k];
              src2_rdy[i] <= lane_rdy2[k];
              bmask[i]    <= lane_bmask[k];
              payload[i]  <= dis_payload[k*PAY_W +: PAY_W];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_station.sv
// Bench for rs_issue_station: directed scenarios followed by a randomized run
// checked against a free-list / ready-queue reference model.
module tb_rs_issue_station;
  localparam int RS_SZ = 8;
  localparam int N     = 2;
  localparam int TAG_W = 6;
  localparam int BM_W  = 4;
  localparam int PAY_W = 32;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [1:0]         num_dispatched;
  logic [N*TAG_W-1:0] dis_dest, dis_src1, dis_src2;
  logic [N-1:0]       dis_src1_rdy, dis_src2_rdy;
  logic [N*BM_W-1:0]  dis_bmask;
  logic [N*PAY_W-1:0] dis_payload;
  logic [1:0]         rs_spots;
  logic [N-1:0]       cdb_valid;
  logic [N*TAG_W-1:0] cdb_tags;
  logic [BM_W-1:0]    b_mm_resolve;
  logic               b_mm_mispred;
  logic [N-1:0]       fu_avail;
  logic [N-1:0]       iss_valid;
  logic [N*TAG_W-1:0] iss_dest, iss_src1, iss_src2;
  logic [N*BM_W-1:0]  iss_bmask;
  logic [N*PAY_W-1:0] iss_payload;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit               m_v  [RS_SZ];
  bit               m_r1 [RS_SZ];
  bit               m_r2 [RS_SZ];
  logic [TAG_W-1:0] m_dest [RS_SZ];
  logic [TAG_W-1:0] m_s1   [RS_SZ];
  logic [TAG_W-1:0] m_s2   [RS_SZ];
  logic [BM_W-1:0]  m_bm   [RS_SZ];
  logic [PAY_W-1:0] m_pay  [RS_SZ];
  bit               m_iss  [RS_SZ];
  int               exp_spots;
  logic [N-1:0]     exp_valid;
  int               exp_ent [N];

  rs_issue_station dut (
    .clock(clock), .reset(reset), .num_dispatched(num_dispatched),
    .dis_dest(dis_dest), .dis_src1(dis_src1), .dis_src2(dis_src2),
    .dis_src1_rdy(dis_src1_rdy), .dis_src2_rdy(dis_src2_rdy),
    .dis_bmask(dis_bmask), .dis_payload(dis_payload), .rs_spots(rs_spots),
    .cdb_valid(cdb_valid), .cdb_tags(cdb_tags), .b_mm_resolve(b_mm_resolve),
    .b_mm_mispred(b_mm_mispred), .fu_avail(fu_avail), .iss_valid(iss_valid),
    .iss_dest(iss_dest), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_bmask(iss_bmask), .iss_payload(iss_payload)
  );

  always #5 clock = ~clock;

  function automatic bit cdb_match(input logic [TAG_W-1:0] t);
    bit hit;
    hit = 1'b0;
    for (int j = 0; j < N; j++)
      if (cdb_valid[j] && cdb_tags[j*TAG_W +: TAG_W] == t) hit = 1'b1;
    return hit;
  endfunction

  task automatic model_eval();
    int el[$];
    int ln[$];
    int free;
    free = 0;
    for (int i = 0; i < RS_SZ; i++) begin
      if (!m_v[i]) free++;
      m_iss[i] = 1'b0;
    end
    exp_spots = (free < N) ? free : N;
    exp_valid = '0;
    for (int k = 0; k < N; k++) exp_ent[k] = 0;
    if (reset) begin
      for (int i = 0; i < RS_SZ; i++)
        if (m_v[i] && m_r1[i] && m_r2[i] && !(b_mm_mispred && (m_bm[i] & b_mm_resolve) != 0))
          el.push_back(i);
      for (int k = 0; k < N; k++)
        if (fu_avail[k]) ln.push_back(k);
      for (int j = 0; j < el.size() && j < ln.size(); j++) begin
        exp_valid[ln[j]] = 1'b1;
        exp_ent[ln[j]]   = el[j];
        m_iss[el[j]]     = 1'b1;
      end
    end
  endtask

  task automatic model_update();
    int fl[$];
    int lim;
    int e;
    logic [BM_W-1:0] lbm;
    model_eval();
    if (!reset) begin
      for (int i = 0; i < RS_SZ; i++) m_v[i] = 1'b0;
      return;
    end
    for (int i = 0; i < RS_SZ; i++) if (!m_v[i]) fl.push_back(i);
    for (int i = 0; i < RS_SZ; i++) if (m_iss[i]) m_v[i] = 1'b0;
    for (int i = 0; i < RS_SZ; i++) begin
      if (m_v[i]) begin
        if (b_mm_mispred && (m_bm[i] & b_mm_resolve) != 0) m_v[i] = 1'b0;
        else begin
          if (cdb_match(m_s1[i])) m_r1[i] = 1'b1;
          if (cdb_match(m_s2[i])) m_r2[i] = 1'b1;
          m_bm[i] = m_bm[i] & ~b_mm_resolve;
        end
      end
    end
    lim = int'(num_dispatched);
    if (fl.size() < lim) lim = fl.size();
    if (N < lim) lim = N;
    for (int k = 0; k < lim; k++) begin
      lbm = dis_bmask[k*BM_W +: BM_W];
      if (!(b_mm_mispred && (lbm & b_mm_resolve) != 0)) begin
        e         = fl[k];
        m_v[e]    = 1'b1;
        m_dest[e] = dis_dest[k*TAG_W +: TAG_W];
        m_s1[e]   = dis_src1[k*TAG_W +: TAG_W];
        m_s2[e]   = dis_src2[k*TAG_W +: TAG_W];
        m_r1[e]   = dis_src1_rdy[k] || cdb_match(m_s1[e]);
        m_r2[e]   = dis_src2_rdy[k] || cdb_match(m_s2[e]);
        m_bm[e]   = lbm & ~b_mm_resolve;
        m_pay[e]  = dis_payload[k*PAY_W +: PAY_W];
      end
    end
  endtask

  task automatic idle();
    reset          = 1'b1;
    num_dispatched = '0;
    dis_dest       = '0;
    dis_src1       = '0;
    dis_src2       = '0;
    dis_src1_rdy   = '0;
    dis_src2_rdy   = '0;
    dis_bmask      = '0;
    dis_payload    = '0;
    cdb_valid      = '0;
    cdb_tags       = '0;
    b_mm_resolve   = '0;
    b_mm_mispred   = 1'b0;
    fu_avail       = '0;
  endtask

  task automatic set_lane(input int k, input int d, input int s1, input int s2,
                          input int r1, input int r2, input int bm, input logic [31:0] pay);
    dis_dest[k*TAG_W +: TAG_W]    = TAG_W'(d);
    dis_src1[k*TAG_W +: TAG_W]    = TAG_W'(s1);
    dis_src2[k*TAG_W +: TAG_W]    = TAG_W'(s2);
    dis_src1_rdy[k]               = 1'(r1);
    dis_src2_rdy[k]               = 1'(r2);
    dis_bmask[k*BM_W +: BM_W]     = BM_W'(bm);
    dis_payload[k*PAY_W +: PAY_W] = pay;
  endtask

  // one clock edge; the model tracks the DUT everywhere, inputs return to idle at the negedge
  task automatic next();
    @(posedge clock);
    model_update();
    @(negedge clock);
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    next();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    fu_avail = 2'b11;
    #1;
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL reset_cycle_iss got %b exp 00", iss_valid); end
    next();
    fu_avail = 2'b11;
    #1;
    checks++; if (rs_spots !== 2'd2) begin errors++; $display("FAIL reset_spots got %0d exp 2", rs_spots); end
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL reset_iss got %b exp 00", iss_valid); end
    next();
  endtask

  task automatic test_dual_issue();
    set_lane(0, 1, 2, 3, 1, 1, 0, 32'hA0);
    set_lane(1, 4, 5, 6, 1, 1, 0, 32'hA1);
    num_dispatched = 2'd2;
    fu_avail = 2'b11;
    #1;
    checks++; if (rs_spots !== 2'd2) begin errors++; $display("FAIL dual_spots_before got %0d exp 2", rs_spots); end
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL dual_no_same_cycle got %b exp 00", iss_valid); end
    next();
    fu_avail = 2'b11;
    #1;
    checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL dual_iss_valid got %b exp 11", iss_valid); end
    checks++; if (iss_payload !== {32'hA1, 32'hA0}) begin errors++; $display("FAIL dual_payload got %h exp %h", iss_payload, {32'hA1, 32'hA0}); end
    checks++; if (iss_dest[5:0] !== 6'd1) begin errors++; $display("FAIL dual_dest got %0d exp 1", iss_dest[5:0]); end
    next();
    fu_avail = 2'b11;
    #1;
    checks++; if (rs_spots !== 2'd2) begin errors++; $display("FAIL dual_spots_after got %0d exp 2", rs_spots); end
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL dual_drained got %b exp 00", iss_valid); end
    next();
  endtask

  task automatic test_fill_wakeup();
    logic [63:0] pay_exp;
    for (int c = 0; c < 4; c++) begin
      set_lane(0, c * 2, 5, 1, 0, 1, 0, 32'h100 + 32'(c * 2));
      set_lane(1, c * 2 + 1, 5, 1, 0, 1, 0, 32'h101 + 32'(c * 2));
      num_dispatched = 2'd2;
      fu_avail = 2'b11;
      #1;
      checks++; if (rs_spots !== 2'd2) begin errors++; $display("FAIL fill_spots step %0d got %0d exp 2", c, rs_spots); end
      next();
    end
    cdb_valid = 2'b01;
    cdb_tags[5:0] = 6'd5;
    fu_avail = 2'b11;
    #1;
    checks++; if (rs_spots !== 2'd0) begin errors++; $display("FAIL full_spots got %0d exp 0", rs_spots); end
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL wake_same_cycle got %b exp 00", iss_valid); end
    next();
    for (int p = 0; p < 4; p++) begin
      fu_avail = 2'b11;
      pay_exp = {32'h101 + 32'(p * 2), 32'h100 + 32'(p * 2)};
      #1;
      checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL drain_valid pair %0d got %b exp 11", p, iss_valid); end
      checks++; if (iss_payload !== pay_exp) begin errors++; $display("FAIL drain_payload pair %0d got %h exp %h", p, iss_payload, pay_exp); end
      checks++; if (rs_spots !== ((p == 0) ? 2'd0 : 2'd2)) begin errors++; $display("FAIL drain_spots pair %0d got %0d", p, rs_spots); end
      next();
    end
    fu_avail = 2'b11;
    #1;
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL drain_empty got %b exp 00", iss_valid); end
    next();
  endtask

  task automatic test_bypass();
    do_reset();
    set_lane(0, 11, 12, 9, 1, 0, 0, 32'hB0);
    set_lane(1, 13, 12, 10, 1, 0, 0, 32'hB1);
    num_dispatched = 2'd2;
    cdb_valid = 2'b10;
    cdb_tags[11:6] = 6'd9;
    fu_avail = 2'b11;
    #1;
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL bypass_same_cycle got %b exp 00", iss_valid); end
    next();
    fu_avail = 2'b11;
    #1;
    checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL bypass_iss got %b exp 01", iss_valid); end
    checks++; if (iss_payload[31:0] !== 32'hB0) begin errors++; $display("FAIL bypass_payload got %h exp b0", iss_payload[31:0]); end
    next();
    fu_avail = 2'b11;
    #1;
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL bypass_other_waits got %b exp 00", iss_valid); end
    next();
  endtask

  task automatic test_resolve_clear();
    do_reset();
    set_lane(0, 1, 20, 2, 0, 1, 4'b0011, 32'hC0);
    set_lane(1, 3, 20, 2, 0, 1, 4'b0100, 32'hC1);
    num_dispatched = 2'd2;
    next();
    set_lane(0, 5, 1, 2, 1, 1, 4'b0001, 32'hC2);
    num_dispatched = 2'd1;
    next();
    set_lane(0, 6, 1, 2, 1, 1, 4'b0001, 32'hC3);
    num_dispatched = 2'd1;
    b_mm_resolve = 4'b0001;
    fu_avail = 2'b01;
    #1;
    checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL resolve_iss got %b exp 01", iss_valid); end
    checks++; if ({iss_bmask[3:0], iss_payload[31:0]} !== {4'b0000, 32'hC2}) begin errors++; $display("FAIL resolve_issue_mask got %b/%h exp 0000/c2", iss_bmask[3:0], iss_payload[31:0]); end
    next();
    cdb_valid = 2'b01;
    cdb_tags[5:0] = 6'd20;
    fu_avail = 2'b01;
    #1;
    checks++; if ({iss_valid, iss_bmask[3:0], iss_payload[31:0]} !== {2'b01, 4'b0000, 32'hC3}) begin errors++; $display("FAIL resolve_dispatch_mask got %b/%b/%h exp 01/0000/c3", iss_valid, iss_bmask[3:0], iss_payload[31:0]); end
    next();
    fu_avail = 2'b11;
    #1;
    checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL resolve_survivors got %b exp 11", iss_valid); end
    checks++; if (iss_bmask !== {4'b0100, 4'b0010}) begin errors++; $display("FAIL resolve_masks got %b exp 01000010", iss_bmask); end
    checks++; if (iss_payload !== {32'hC1, 32'hC0}) begin errors++; $display("FAIL resolve_payload got %h exp c1c0", iss_payload); end
    next();
  endtask

  task automatic test_mispred();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      set_lane(0, 0, 30, 1, 0, 1, 0, 32'hF0 + 32'(c * 2));
      set_lane(1, 0, 30, 1, 0, 1, 0, 32'hF1 + 32'(c * 2));
      num_dispatched = 2'd2;
      next();
    end
    set_lane(0, 0, 30, 1, 0, 1, 0, 32'hF4);
    set_lane(1, 7, 1, 2, 1, 1, 4'b0010, 32'hE0);
    num_dispatched = 2'd2;
    next();
    set_lane(0, 8, 1, 2, 1, 1, 4'b0110, 32'hE1);
    set_lane(1, 9, 1, 2, 1, 1, 4'b1000, 32'hE2);
    num_dispatched = 2'd2;
    next();
    b_mm_resolve = 4'b0010;
    b_mm_mispred = 1'b1;
    fu_avail = 2'b11;
    #1;
    checks++; if (rs_spots !== 2'd0) begin errors++; $display("FAIL mispred_spots_now got %0d exp 0", rs_spots); end
    checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL mispred_iss got %b exp 01", iss_valid); end
    checks++; if ({iss_bmask[3:0], iss_payload[31:0]} !== {4'b1000, 32'hE2}) begin errors++; $display("FAIL mispred_survivor got %b/%h exp 1000/e2", iss_bmask[3:0], iss_payload[31:0]); end
    next();
    set_lane(0, 10, 1, 2, 1, 1, 4'b0001, 32'hE3);
    set_lane(1, 11, 1, 2, 1, 1, 4'b0000, 32'hE4);
    num_dispatched = 2'd2;
    b_mm_resolve = 4'b0001;
    b_mm_mispred = 1'b1;
    fu_avail = 2'b11;
    #1;
    checks++; if (rs_spots !== 2'd2) begin errors++; $display("FAIL mispred_spots_later got %0d exp 2", rs_spots); end
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL mispred_squashed_gone got %b exp 00", iss_valid); end
    next();
    fu_avail = 2'b11;
    #1;
    checks++; if ({iss_valid, iss_payload[31:0]} !== {2'b01, 32'hE4}) begin errors++; $display("FAIL mispred_lane_kill got %b/%h exp 01/e4", iss_valid, iss_payload[31:0]); end
    next();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_lane(0, c, 1, 2, 1, 1, 0, 32'hD0 + 32'(c));
      set_lane(1, c, 1, 2, 1, 1, 0, 32'hD8 + 32'(c));
      num_dispatched = (c == 2) ? 2'd1 : 2'd2;
      next();
    end
    reset = 1'b0;
    fu_avail = 2'b11;
    #1;
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL midreset_iss got %b exp 00", iss_valid); end
    next();
    fu_avail = 2'b11;
    #1;
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL midreset_cleared got %b exp 00", iss_valid); end
    checks++; if (rs_spots !== 2'd2) begin errors++; $display("FAIL midreset_spots got %0d exp 2", rs_spots); end
    next();
  endtask

  task automatic test_random();
    int e;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      model_eval();
      num_dispatched = 2'($urandom_range(0, exp_spots));
      for (int k = 0; k < N; k++)
        set_lane(k, $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 7),
                 ($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 15), $urandom);
      cdb_valid = 2'($urandom);
      cdb_tags  = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      if ($urandom_range(0, 3) == 0) begin
        b_mm_resolve = 4'(1 << $urandom_range(0, 3));
        b_mm_mispred = 1'($urandom_range(0, 1));
      end
      fu_avail = 2'($urandom);
      reset = ($urandom_range(0, 63) != 0);
      #1;
      model_eval();
      checks++; if (rs_spots !== 2'(exp_spots)) begin errors++; $display("FAIL rand_spots cyc %0d got %0d exp %0d", cyc, rs_spots, exp_spots); end
      checks++; if (iss_valid !== exp_valid) begin errors++; $display("FAIL rand_iss_valid cyc %0d got %b exp %b", cyc, iss_valid, exp_valid); end
      for (int k = 0; k < N; k++) begin
        if (exp_valid[k] && iss_valid[k]) begin
          e = exp_ent[k];
          checks++;
          if ({iss_dest[k*TAG_W +: TAG_W], iss_src1[k*TAG_W +: TAG_W], iss_src2[k*TAG_W +: TAG_W],
               iss_bmask[k*BM_W +: BM_W], iss_payload[k*PAY_W +: PAY_W]} !==
              {m_dest[e], m_s1[e], m_s2[e], m_bm[e] & ~b_mm_resolve, m_pay[e]}) begin
            errors++;
            $display("FAIL rand_lane%0d cyc %0d got %h/%h/%h/%b/%h exp %h/%h/%h/%b/%h", k, cyc,
                     iss_dest[k*TAG_W +: TAG_W], iss_src1[k*TAG_W +: TAG_W], iss_src2[k*TAG_W +: TAG_W],
                     iss_bmask[k*BM_W +: BM_W], iss_payload[k*PAY_W +: PAY_W],
                     m_dest[e], m_s1[e], m_s2[e], m_bm[e] & ~b_mm_resolve, m_pay[e]);
          end
        end
      end
      next();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_dual_issue();
    test_fill_wakeup();
    test_bypass();
    test_resolve_clear();
    test_mispred();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
